// File: rtl/gpr_regfile_mp_if.sv
// gpr_regfile_mp_if: bus bundle for the multi-port GPR file.
// Ports: clear_i, ready_o, re_i/raddr_i/rdata_o/pend_o (read side),
// we_i/waddr_i/wdata_i (write side), iss_i/iss_addr_i (issue side).
interface gpr_regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NR_RD  = 2,
    parameter int NR_WR  = 1
);
    logic                    clear_i;
    logic                    ready_o;
    logic [NR_RD-1:0]        re_i;
    logic [NR_RD*ADDR_W-1:0] raddr_i;
    logic [NR_RD*DATA_W-1:0] rdata_o;
    logic [NR_RD-1:0]        pend_o;
    logic [NR_WR-1:0]        we_i;
    logic [NR_WR*ADDR_W-1:0] waddr_i;
    logic [NR_WR*DATA_W-1:0] wdata_i;
    logic                    iss_i;
    logic [ADDR_W-1:0]       iss_addr_i;

    modport master (
        output clear_i, re_i, raddr_i, we_i, waddr_i, wdata_i, iss_i, iss_addr_i,
        input  ready_o, rdata_o, pend_o
    );
    modport slave (
        input  clear_i, re_i, raddr_i, we_i, waddr_i, wdata_i, iss_i, iss_addr_i,
        output ready_o, rdata_o, pend_o
    );
endinterface

// File: rtl/gpr_regfile_mp.sv
// gpr_regfile_mp: parametrised GPR file with bypass, pending scoreboard and clear sweep.
// Ports: clk, rst (async active-high), bus (slave side of gpr_regfile_mp_if):
//   clear_i re-zeroes array and scoreboard, ready_o high in RUN,
//   re_i/raddr_i -> rdata_o/pend_o combinational reads, we_i/waddr_i/wdata_i writes,
//   iss_i/iss_addr_i marks a destination register pending.
module gpr_regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NR_RD    = 2,
    parameter int NR_WR    = 1,
    parameter int ZERO_REG = 1
) (
    input logic             clk,
    input logic             rst,
    gpr_regfile_mp_if.slave bus
);
    localparam logic ZR = (ZERO_REG != 0);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   clr_idx_q;
    logic                ready_q;
    logic [DEPTH-1:0]    pend_q, pend_d;
    logic [DATA_W-1:0]   gpr_q [DEPTH];

    // Ascending port order makes the higher-indexed port win a collision;
    // the issue set is applied last so a new producer supersedes a writeback.
    always_comb begin
        pend_d = pend_q;
        for (int j = 0; j < NR_WR; j++)
            if (bus.we_i[j]) pend_d[bus.waddr_i[j*ADDR_W +: ADDR_W]] = 1'b0;
        if (bus.iss_i && !(ZR && bus.iss_addr_i == '0)) pend_d[bus.iss_addr_i] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
            pend_q    <= '0;
        end else if (state_q == CLEAR) begin
            clr_idx_q <= clr_idx_q + 1'b1;
            if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
                state_q <= RUN;
                ready_q <= 1'b1;
            end
        end else if (bus.clear_i) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
            pend_q    <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Storage has no reset; the CLEAR sweep zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            gpr_q[clr_idx_q] <= '0;
        end else if (!bus.clear_i) begin
            for (int j = 0; j < NR_WR; j++)
                if (bus.we_i[j] && !(ZR && bus.waddr_i[j*ADDR_W +: ADDR_W] == '0))
                    gpr_q[bus.waddr_i[j*ADDR_W +: ADDR_W]] <= bus.wdata_i[j*DATA_W +: DATA_W];
        end
    end

    assign bus.ready_o = ready_q;

    for (genvar k = 0; k < NR_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit;
        logic              live;
        logic [DATA_W-1:0] bd;
        assign ra = bus.raddr_i[k*ADDR_W +: ADDR_W];
        always_comb begin
            hit = 1'b0;
            bd  = gpr_q[ra];
            for (int j = 0; j < NR_WR; j++)
                if (bus.we_i[j] && bus.waddr_i[j*ADDR_W +: ADDR_W] == ra) begin
                    hit = 1'b1;
                    bd  = bus.wdata_i[j*DATA_W +: DATA_W];
                end
        end
        assign live = ready_q && bus.re_i[k] && !(ZR && ra == '0);
        assign bus.rdata_o[k*DATA_W +: DATA_W] = live ? bd : '0;
        // A value being bypassed this cycle is already available, so never pending.
        assign bus.pend_o[k] = live & pend_q[ra] & ~hit;
    end
endmodule

// File: tb/tb_gpr_regfile_mp.sv
// tb_gpr_regfile_mp: self-checking bench for gpr_regfile_mp (table vectors + scoreboard queue).
module tb_gpr_regfile_mp;
    logic clk;
    logic rst;

    gpr_regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NR_RD(2), .NR_WR(2)) bus_a ();
    gpr_regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NR_RD(1), .NR_WR(1)) bus_b ();

    gpr_regfile_mp #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .NR_RD(2), .NR_WR(2), .ZERO_REG(1))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    gpr_regfile_mp #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .NR_RD(1), .NR_WR(1), .ZERO_REG(0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        logic [1:0]  re;
        logic [4:0]  ra0, ra1;
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        iss;
        logic [4:0]  ia;
        logic [31:0] er0, er1;
        logic [1:0]  ep;
    } vec_t;

    typedef struct {
        logic [31:0] r0, r1;
        logic [1:0]  p;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[17];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_a();
        bus_a.clear_i = 1'b0; bus_a.re_i = '0; bus_a.raddr_i = '0;
        bus_a.we_i = '0; bus_a.waddr_i = '0; bus_a.wdata_i = '0;
        bus_a.iss_i = 1'b0; bus_a.iss_addr_i = '0;
    endtask

    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        @(posedge clk); #1;
        bus_a.re_i = v.re; bus_a.raddr_i = {v.ra1, v.ra0};
        bus_a.we_i = v.we; bus_a.waddr_i = {v.wa1, v.wa0}; bus_a.wdata_i = {v.wd1, v.wd0};
        bus_a.iss_i = v.iss; bus_a.iss_addr_i = v.ia;
        sbq.push_back('{v.er0, v.er1, v.ep});
        @(negedge clk);
        e = sbq.pop_front();
        chk({tag, ".rd0"}, bus_a.rdata_o[31:0], e.r0);
        chk({tag, ".rd1"}, bus_a.rdata_o[63:32], e.r1);
        chk({tag, ".pend"}, {30'd0, bus_a.pend_o}, {30'd0, e.p});
    endtask

    task automatic rd_pair(input logic [4:0] a0, input logic [4:0] a1, input string tag);
        apply('{2'b11, a0, a1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00}, tag);
    endtask

    // After the edge that enters CLEAR, ready must stay low until exactly 32 more edges.
    task automatic sweep_count(input string tag);
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            chk($sformatf("%s.ready@%0d", tag, k), {31'd0, bus_a.ready_o}, {31'd0, (k == 32)});
        end
    endtask

    initial begin
        //        re     ra0    ra1    we     wa0    wa1    wd0           wd1       iss   ia     er0           er1           ep
        tbl[0]  = '{2'b00, 5'd0,  5'd0,  2'b01, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0,    1'b0, 5'd0,  32'h0,        32'h0,        2'b00};
        tbl[1]  = '{2'b11, 5'd5,  5'd5,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    1'b0, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
        tbl[2]  = '{2'b11, 5'd7,  5'd5,  2'b01, 5'd7,  5'd0,  32'h1234,     32'h0,    1'b0, 5'd0,  32'h1234,     32'hDEADBEEF, 2'b00};
        tbl[3]  = '{2'b11, 5'd7,  5'd7,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    1'b0, 5'd0,  32'h1234,     32'h1234,     2'b00};
        tbl[4]  = '{2'b11, 5'd0,  5'd0,  2'b01, 5'd0,  5'd0,  32'hFFFFFFFF, 32'h0,    1'b1, 5'd0,  32'h0,        32'h0,        2'b00};
        tbl[5]  = '{2'b11, 5'd0,  5'd0,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    1'b0, 5'd0,  32'h0,        32'h0,        2'b00};
        tbl[6]  = '{2'b11, 5'd9,  5'd9,  2'b11, 5'd9,  5'd9,  32'h11,       32'h22,   1'b0, 5'd0,  32'h22,       32'h22,       2'b00};
        tbl[7]  = '{2'b11, 5'd9,  5'd9,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    1'b0, 5'd0,  32'h22,       32'h22,       2'b00};
        tbl[8]  = '{2'b11, 5'd3,  5'd3,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    1'b1, 5'd3,  32'h0,        32'h0,        2'b00};
        tbl[9]  = '{2'b11, 5'd3,  5'd3,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    1'b0, 5'd0,  32'h0,        32'h0,        2'b11};
        tbl[10] = '{2'b01, 5'd3,  5'd3,  2'b10, 5'd0,  5'd3,  32'h0,        32'h33,   1'b0, 5'd0,  32'h33,       32'h0,        2'b00};
        tbl[11] = '{2'b11, 5'd3,  5'd3,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    1'b0, 5'd0,  32'h33,       32'h33,       2'b00};
        tbl[12] = '{2'b11, 5'd3,  5'd3,  2'b01, 5'd3,  5'd0,  32'h44,       32'h0,    1'b1, 5'd3,  32'h44,       32'h44,       2'b00};
        tbl[13] = '{2'b11, 5'd3,  5'd3,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    1'b0, 5'd0,  32'h44,       32'h44,       2'b11};
        tbl[14] = '{2'b10, 5'd3,  5'd3,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    1'b0, 5'd0,  32'h0,        32'h44,       2'b10};
        tbl[15] = '{2'b00, 5'd0,  5'd0,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    1'b1, 5'd5,  32'h0,        32'h0,        2'b00};
        tbl[16] = '{2'b11, 5'd5,  5'd5,  2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    1'b0, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 2'b11};

        idle_a();
        bus_b.clear_i = 1'b0; bus_b.re_i = '0; bus_b.raddr_i = '0; bus_b.we_i = '0;
        bus_b.waddr_i = '0; bus_b.wdata_i = '0; bus_b.iss_i = 1'b0; bus_b.iss_addr_i = '0;
        rst = 1'b1;
        #1;
        chk("reset.ready", {31'd0, bus_a.ready_o}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Writes and issues attempted during the power-up sweep must be dropped.
        bus_a.we_i = 2'b11; bus_a.waddr_i = {5'd6, 5'd5}; bus_a.wdata_i = {32'h6666, 32'h5555};
        bus_a.iss_i = 1'b1; bus_a.iss_addr_i = 5'd5;
        bus_a.re_i = 2'b11; bus_a.raddr_i = {5'd6, 5'd5};
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            chk($sformatf("boot.ready@%0d", k), {31'd0, bus_a.ready_o}, {31'd0, (k == 32)});
            if (k < 32) begin
                chk($sformatf("boot.rdata@%0d", k), bus_a.rdata_o[31:0] | bus_a.rdata_o[63:32], 32'h0);
                chk($sformatf("boot.pend@%0d", k), {30'd0, bus_a.pend_o}, 32'd0);
            end else begin
                idle_a();
            end
        end
        chk("boot.ready_b", {31'd0, bus_b.ready_o}, 32'd1);

        for (int a = 0; a < 16; a++) rd_pair(5'(2 * a), 5'(2 * a + 1), $sformatf("zero%0d", a));

        for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("v%0d", i));

        // ZERO_REG=0 instance: r0 behaves as an ordinary register.
        @(posedge clk); #1;
        idle_a();
        bus_b.we_i = 1'b1; bus_b.waddr_i = 5'd0; bus_b.wdata_i = 32'hFFFFFFFF;
        bus_b.re_i = 1'b1; bus_b.raddr_i = 5'd0; bus_b.iss_i = 1'b1; bus_b.iss_addr_i = 5'd0;
        @(negedge clk);
        chk("b.r0.bypass", bus_b.rdata_o, 32'hFFFFFFFF);
        chk("b.r0.pend_bypass", {31'd0, bus_b.pend_o}, 32'd0);
        @(posedge clk); #1;
        bus_b.we_i = 1'b0; bus_b.iss_i = 1'b0;
        @(negedge clk);
        chk("b.r0.readback", bus_b.rdata_o, 32'hFFFFFFFF);
        chk("b.r0.pend", {31'd0, bus_b.pend_o}, 32'd1);

        // clear_i in RUN: same-cycle write/issue to r6 discarded, full 32-edge sweep.
        @(posedge clk); #1;
        bus_a.clear_i = 1'b1; bus_a.we_i = 2'b01; bus_a.waddr_i = {5'd0, 5'd6};
        bus_a.wdata_i = {32'h0, 32'h66}; bus_a.iss_i = 1'b1; bus_a.iss_addr_i = 5'd6;
        @(posedge clk); #1;
        idle_a();
        chk("clr.ready@0", {31'd0, bus_a.ready_o}, 32'd0);
        sweep_count("clr");
        rd_pair(5'd5, 5'd3, "clr.r5r3");
        rd_pair(5'd6, 5'd9, "clr.r6r9");

        // Reset in the middle of a sweep (clr_idx=10) restarts it from index 0.
        @(posedge clk); #1;
        bus_a.clear_i = 1'b1;
        @(posedge clk); #1;
        bus_a.clear_i = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            chk($sformatf("mid.ready@%0d", k), {31'd0, bus_a.ready_o}, 32'd0);
        end
        rst = 1'b1;
        #1;
        chk("mid.rst.ready", {31'd0, bus_a.ready_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sweep_count("rst");
        rd_pair(5'd7, 5'd5, "rst.r7r5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
